gcd_job_scheduler: RTL and testbench

Shares one subtractive GCD datapath (A/B registers, subtractor, comparator) among NREQ requesters. Round-robin arbitration grants one request at a time. The block latches the request's operands, sequences the datapath through load and subtract steps, and returns the result with the requester id over a valid/ready response channel. It replaces the single-user GCD controller whenever several masters need GCD service.

---
 rtl/gcd_job_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_gcd_job_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_scheduler.sv
// gcd_job_scheduler
//   Lets NREQ requesters share one external subtractive GCD datapath.
//   Requesters are served one job at a time, picked round-robin. The
//   controller sequences the datapath and returns each result, tagged with
//   the requester id, over a valid/ready response channel.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   W         operand/result width
//   MAX_ITER  subtraction limit per job (only with GCD_TIMEOUT_EN)
//
// Build option
//   GCD_TIMEOUT_EN  when defined, a job is aborted with rsp_err=1 once it
//                   has used MAX_ITER subtractions without reaching eq.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req/opa/opb           per-requester request and packed operands
//   grant                 one-hot pulse; operands captured on that edge
//   dp_data_in, sel_in,   datapath input mux and subtractor select
//   sel1, sel2, ldA, ldB  datapath control and register loads
//   lt, gt, eq, dp_result datapath comparator flags and A register value
//   busy                  controller is not idle
//   rsp_*                 response channel (valid/ready, id, data, err)
//
// State | meaning
//   IDLE   | arbitrate and capture a job
//   LOAD_A | load A register from latched operand A
//   LOAD_B | load B register from latched operand B
//   CMP    | subtract until equal
//   RESP   | hold response until accepted
module gcd_job_scheduler #(
  parameter int NREQ     = 4,
  parameter int W        = 16,
  parameter int MAX_ITER = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ*W-1:0]                    opa,
  input  logic [NREQ*W-1:0]                    opb,
  output logic [NREQ-1:0]                      grant,
  output logic [W-1:0]                         dp_data_in,
  output logic                                 sel_in,
  output logic                                 sel1,
  output logic                                 sel2,
  output logic                                 ldA,
  output logic                                 ldB,
  input  logic                                 lt,
  input  logic                                 gt,
  input  logic                                 eq,
  input  logic [W-1:0]                         dp_result,
  output logic                                 busy,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [((NREQ>1)?$clog2(NREQ):1)-1:0] rsp_id,
  output logic [W-1:0]                         rsp_data,
  output logic                                 rsp_err
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_CMP, S_RESP} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_ptr, r_id;
  logic [W-1:0]   r_opa, r_opb, r_rsp_data;
  logic           r_rsp_err;

  logic           w_hit;
  logic [IDW-1:0] w_win, w_cand;
  logic [W-1:0]   w_opa, w_opb;
  logic           w_zero;
  logic           w_tmo;

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    w_hit  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = IDW'((int'(r_ptr) + i) % NREQ);
      if (!w_hit && req[w_cand]) begin
        w_hit = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_opa  = opa[int'(w_win)*W +: W];
  assign w_opb  = opb[int'(w_win)*W +: W];
  assign w_zero = (w_opa == '0) || (w_opb == '0);

`ifdef GCD_TIMEOUT_EN
  localparam int ITW = $clog2(MAX_ITER + 1);
  logic [ITW-1:0] r_iter;

  assign w_tmo = (r_iter == ITW'(MAX_ITER));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_iter <= '0;
    else if (r_state == S_LOAD_A)
      r_iter <= '0;
    else if ((r_state == S_CMP) && !eq && !w_tmo && (lt || gt))
      r_iter <= r_iter + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    grant       = '0;
    dp_data_in  = '0;
    sel_in      = 1'b0;
    sel1        = 1'b0;
    sel2        = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          grant       = NREQ'(1) << w_win;
          w_state_nxt = w_zero ? S_RESP : S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        dp_data_in  = r_opa;
        sel_in      = 1'b1;
        ldA         = 1'b1;
        w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        dp_data_in  = r_opb;
        sel_in      = 1'b1;
        ldB         = 1'b1;
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
        // eq wins over the limit so a job finishing on its last allowed step still succeeds
        if (eq || w_tmo) begin
          w_state_nxt = S_RESP;
        end else if (lt) begin
          sel1 = 1'b1;
          ldB  = 1'b1;
        end else if (gt) begin
          sel2 = 1'b1;
          ldA  = 1'b1;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_id  <= w_win;
            r_opa <= w_opa;
            r_opb <= w_opb;
            if (w_zero) begin
              r_rsp_data <= (w_opa == '0) ? w_opb : w_opa;
              r_rsp_err  <= (w_opa == '0) && (w_opb == '0);
            end
          end
        end
        S_CMP: begin
          if (eq) begin
            r_rsp_data <= dp_result;
            r_rsp_err  <= 1'b0;
          end else if (w_tmo || (!lt && !gt)) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready)
            r_ptr <= (int'(r_id) == NREQ - 1) ? '0 : r_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
`timescale 1ns/1ps
module tb_gcd_job_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 16;
`ifdef GCD_TIMEOUT_EN
  localparam int MI = 4;
`else
  localparam int MI = 1024;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opa, opb;
  logic [NREQ-1:0]   grant;
  logic [W-1:0]      dp_data_in;
  logic              sel_in, sel1, sel2, ldA, ldB;
  logic              lt, gt, eq;
  logic [W-1:0]      dp_result;
  logic              busy, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;

  always #5 clk = ~clk;

  gcd_job_scheduler #(.NREQ(NREQ), .W(W), .MAX_ITER(MI)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb), .grant(grant),
    .dp_data_in(dp_data_in), .sel_in(sel_in), .sel1(sel1), .sel2(sel2),
    .ldA(ldA), .ldB(ldB), .lt(lt), .gt(gt), .eq(eq), .dp_result(dp_result),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Behavioural model of the shared GCD datapath.
  logic [W-1:0] ra = '0, rb = '0;
  wire  [W-1:0] sub = (sel1 && !sel2) ? rb - ra : ra - rb;
  always @(posedge clk) begin
    if (ldA) ra <= sel_in ? dp_data_in : sub;
    if (ldB) rb <= sel_in ? dp_data_in : sub;
  end
  assign lt = ra < rb;
  assign gt = ra > rb;
  assign eq = ra == rb;
  assign dp_result = ra;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {busy, rsp_valid, grant, ldA, ldB, sel1, sel2, sel_in, dp_data_in, rsp_id, rsp_data, rsp_err};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset outputs", all_outs(), 64'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string nm, output bit ok);
    int cnt = 0;
    #1;
    while (grant == '0 && cnt < 50) begin
      step();
      #1;
      cnt++;
    end
    ok = (grant != '0);
    if (!ok) chk({nm, " grant timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input string nm);
    int cnt = 0;
    while (!rsp_valid && cnt < 1200) begin
      step();
      #1;
      cnt++;
    end
    if (!rsp_valid) chk({nm, " rsp timeout"}, 64'd0, 64'd1);
  endtask

  task automatic handshake(input string nm);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    chk({nm, " post-accept valid"}, rsp_valid, 1'b0);
  endtask

  task automatic run_job(input int id, input int a, input int b, input int ed,
                         input int ee, input int elat, input string tag);
    bit ok;
    int lat = 0;
    int lds = 0;
    req[id] = 1'b1;
    opa[id*W +: W] = W'(a);
    opb[id*W +: W] = W'(b);
    wait_grant(tag, ok);
    if (!ok) begin
      req[id] = 1'b0;
      return;
    end
    chk({tag, " grant"}, grant, 64'(1) << id);
    do begin
      step();
      req[id] = 1'b0;
      #1;
      lat++;
      if (ldA || ldB) lds++;
      if (lat == 1 && elat > 1) chk({tag, " loadA"}, {ldA, ldB, sel_in, dp_data_in}, {3'b101, W'(a)});
      if (lat == 2 && elat > 2) chk({tag, " loadB"}, {ldA, ldB, sel_in, dp_data_in}, {3'b011, W'(b)});
    end while (!rsp_valid && lat < 1200);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " rsp"}, {busy, rsp_id, rsp_data, rsp_err}, {1'b1, 2'(id), W'(ed), 1'(ee)});
    if (elat == 1) chk({tag, " no loads"}, lds, 0);
    handshake(tag);
  endtask

  typedef struct {int id; int a; int b; int d; int e; int lat;} vec_t;
  vec_t tbl[9];

  initial begin
    bit ok;
    int gid;
    int rr_exp[5];
    req = '0; opa = '0; opb = '0; rsp_ready = 1'b0;

    tbl[0] = '{0, 12, 8, 4, 0, 6};
    tbl[1] = '{2, 0, 9, 9, 0, 1};
    tbl[2] = '{2, 0, 0, 0, 1, 1};
    tbl[3] = '{1, 9, 0, 9, 0, 1};
    tbl[4] = '{3, 7, 7, 7, 0, 4};
    tbl[5] = '{1, 15, 10, 5, 0, 6};
    tbl[6] = '{0, 21, 6, 3, 0, 8};
    tbl[7] = '{2, 8, 12, 4, 0, 6};
`ifdef GCD_TIMEOUT_EN
    tbl[8] = '{3, 100, 1, 0, 1, 8};
`else
    tbl[8] = '{3, 100, 1, 1, 0, 103};
`endif

    do_reset();
    step();
    for (int i = 0; i < 9; i++) run_job(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e, tbl[i].lat, $sformatf("vec%0d", i));

    // Round robin with all requesters pending, requester 0 re-requesting.
    do_reset();
    rr_exp = '{0, 1, 2, 3, 0};
    for (int k = 0; k < NREQ; k++) begin
      opa[k*W +: W] = 16'd6;
      opb[k*W +: W] = 16'd3;
    end
    req = '1;
    for (int n = 0; n < 5; n++) begin
      wait_grant("rr", ok);
      if (!ok) break;
      gid = 0;
      for (int k = 0; k < NREQ; k++) if (grant[k]) gid = k;
      chk($sformatf("rr order %0d", n), gid, rr_exp[n]);
      step();
      req[gid] = 1'b0;
      if (n == 1) req[0] = 1'b1;
      #1;
      wait_valid("rr");
      chk("rr rsp", {rsp_id, rsp_data}, {2'(gid), 16'd3});
      handshake("rr");
    end
    req = '0;

    // Response back-pressure with another request waiting.
    do_reset();
    opa[0 +: W] = 16'd5; opb[0 +: W] = 16'd5;
    req[0] = 1'b1;
    wait_grant("bp", ok);
    step();
    req[0] = 1'b0;
    opa[W +: W] = 16'd3; opb[W +: W] = 16'd6;
    req[1] = 1'b1;
    #1;
    wait_valid("bp");
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp hold %0d", c), {rsp_valid, rsp_id, rsp_data, grant}, {1'b1, 2'd0, 16'd5, 4'd0});
      step();
      #1;
    end
    handshake("bp");
    chk("bp next grant", grant, 4'b0010);
    step();
    req[1] = 1'b0;
    #1;
    wait_valid("bp2");
    chk("bp2 rsp", {rsp_id, rsp_data, rsp_err}, {2'd1, 16'd3, 1'b0});
    handshake("bp2");

    // Reset in the middle of a CMP phase.
    opa[2*W +: W] = 16'd100; opb[2*W +: W] = 16'd75;
    req[2] = 1'b1;
    wait_grant("mid", ok);
    step();
    req[2] = 1'b0;
    step();
    step();
    step();
    chk("mid busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid reset outputs", all_outs(), 64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("mid idle %0d", c), {busy, rsp_valid}, 2'b00);
    end
    opa[W +: W] = 16'd4; opb[W +: W] = 16'd2;
    opa[3*W +: W] = 16'd4; opb[3*W +: W] = 16'd2;
    req = 4'b1010;
    #1;
    chk("mid regrant", grant, 4'b0010);
    step();
    req = '0;
    #1;
    wait_valid("mid2");
    chk("mid2 rsp", {rsp_id, rsp_data, rsp_err}, {2'd1, 16'd2, 1'b0});
    handshake("mid2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
